// File: rtl/fifo_flex.sv
// fifo_flex: parametrised valid/ready FIFO with occupancy, watermarks,
// high-water mark, synchronous flush and optional fall-through bypass.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high on that side (push = in_val & in_rdy, pop = out_val &
// out_rdy). in_rdy depends only on registered occupancy and flush, never on
// out_rdy; out_val may depend on in_val only in bypass mode when empty.
module fifo_flex #(
  parameter int DEPTH_IDX = 2,
  parameter int WIDTH     = 8,
  parameter int BYPASS    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_data,
  input  logic [DEPTH_IDX:0]   afull_thr,
  input  logic [DEPTH_IDX:0]   aempty_thr,
  output logic [DEPTH_IDX:0]   count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [DEPTH_IDX:0]   max_count
);

  localparam int DEPTH = 1 << DEPTH_IDX;
  localparam logic [DEPTH_IDX:0]   FULL_CNT = (DEPTH_IDX+1)'(DEPTH);
  localparam logic [DEPTH_IDX:0]   CNT_ONE  = (DEPTH_IDX+1)'(1);
  localparam logic [DEPTH_IDX-1:0] PTR_ONE  = DEPTH_IDX'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [DEPTH_IDX-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_IDX-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_IDX:0]   count_q, count_d;
  logic [DEPTH_IDX:0]   max_count_q, max_count_d;

  logic bypass_hit;
  logic bypass_take;
  logic push;
  logic pop;
  logic do_wr;
  logic do_rd;

  // Handshake outputs; a bypassed word consumed in the same cycle never touches storage.
  always_comb begin
    bypass_hit  = (BYPASS != 0) && (count_q == '0) && in_val && !flush;
    in_rdy      = (count_q != FULL_CNT) && !flush;
    out_val     = ((count_q != '0) || bypass_hit) && !flush;
    out_data    = bypass_hit ? in_data : mem_q[rd_ptr_q];
    push        = in_val && in_rdy;
    pop         = out_val && out_rdy;
    bypass_take = bypass_hit && out_rdy;
    do_wr       = push && !bypass_take;
    do_rd       = pop && !bypass_take;
  end

  // Next-state for storage, pointers, occupancy and high-water mark; flush clears all but storage.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    max_count_d = max_count_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      max_count_d = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_wr && !do_rd) begin
        count_d = count_q + CNT_ONE;
      end else if (do_rd && !do_wr) begin
        count_d = count_q - CNT_ONE;
      end
      max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
    end
  end

  // Storage array is deliberately not reset; stale data is unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count        = count_q;
  assign max_count    = max_count_q;
  assign almost_full  = (count_q >= afull_thr);
  assign almost_empty = (count_q <= aempty_thr);

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one instance without bypass (index 0) and one with
// bypass (index 1), both fed the same stimulus.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_val;
  logic       out_rdy;
  logic [7:0] in_data;
  logic [2:0] afull_thr;
  logic [2:0] aempty_thr;

  logic       o_in_rdy  [2];
  logic       o_out_val [2];
  logic [7:0] o_out_data[2];
  logic [2:0] o_count   [2];
  logic [2:0] o_max     [2];
  logic       o_af      [2];
  logic       o_ae      [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mq[2][$];
  int         mmax[2];

  always #5 clk = ~clk;

  fifo_flex #(.DEPTH_IDX(2), .WIDTH(8), .BYPASS(0)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_val(in_val), .in_rdy(o_in_rdy[0]), .in_data(in_data),
    .out_val(o_out_val[0]), .out_rdy(out_rdy), .out_data(o_out_data[0]),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .count(o_count[0]), .almost_full(o_af[0]), .almost_empty(o_ae[0]),
    .max_count(o_max[0])
  );

  fifo_flex #(.DEPTH_IDX(2), .WIDTH(8), .BYPASS(1)) u_fifo_byp (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_val(in_val), .in_rdy(o_in_rdy[1]), .in_data(in_data),
    .out_val(o_out_val[1]), .out_rdy(out_rdy), .out_data(o_out_data[1]),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .count(o_count[1]), .almost_full(o_af[1]), .almost_empty(o_ae[1]),
    .max_count(o_max[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_val = 1'b1; in_data = d; out_rdy = 1'b0;
    tick();
    in_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_data = '0;
    afull_thr = 3'd0; aempty_thr = 3'd0;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_count[k] !== 3'd0) begin failures++; $display("FAIL reset_count[%0d] act=%0d exp=0", k, o_count[k]); end
      checks++; if (o_in_rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_in_rdy[%0d] act=%b exp=1", k, o_in_rdy[k]); end
      checks++; if (o_out_val[k] !== 1'b0) begin failures++; $display("FAIL reset_out_val[%0d] act=%b exp=0", k, o_out_val[k]); end
      checks++; if (o_max[k] !== 3'd0) begin failures++; $display("FAIL reset_max[%0d] act=%0d exp=0", k, o_max[k]); end
      checks++; if (o_ae[k] !== 1'b1) begin failures++; $display("FAIL reset_aempty[%0d] act=%b exp=1", k, o_ae[k]); end
      checks++; if (o_af[k] !== 1'b1) begin failures++; $display("FAIL reset_afull_thr0[%0d] act=%b exp=1", k, o_af[k]); end
    end
    afull_thr = 3'd3;
    #1;
    checks++; if (o_af[0] !== 1'b0) begin failures++; $display("FAIL reset_afull_thr3 act=%b exp=0", o_af[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (o_count[0] !== 3'd0) begin failures++; $display("FAIL post_reset_count act=%0d exp=0", o_count[0]); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    do_flush();
    afull_thr = 3'd7; aempty_thr = 3'd0;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_data = words[i]; out_rdy = 1'b0;
      #1;
      checks++; if (o_in_rdy[0] !== 1'b1) begin failures++; $display("FAIL fill_in_rdy i=%0d act=%b exp=1", i, o_in_rdy[0]); end
      tick();
      checks++; if (o_count[0] !== 3'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d act=%0d exp=%0d", i, o_count[0], i + 1); end
    end
    in_data = 8'h55;
    #1;
    checks++; if (o_in_rdy[0] !== 1'b0) begin failures++; $display("FAIL full_in_rdy act=%b exp=0", o_in_rdy[0]); end
    tick();
    checks++; if (o_count[0] !== 3'd4) begin failures++; $display("FAIL stall_count act=%0d exp=4", o_count[0]); end
    in_val = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_out_val[0] !== 1'b1) begin failures++; $display("FAIL drain_val i=%0d act=%b exp=1", i, o_out_val[0]); end
      checks++; if (o_out_data[0] !== words[i]) begin failures++; $display("FAIL drain_data i=%0d act=%h exp=%h", i, o_out_data[0], words[i]); end
      tick();
    end
    #1;
    checks++; if (o_count[0] !== 3'd0) begin failures++; $display("FAIL drain_count act=%0d exp=0", o_count[0]); end
    checks++; if (o_out_val[0] !== 1'b0) begin failures++; $display("FAIL drain_empty_val act=%b exp=0", o_out_val[0]); end
    out_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    do_flush();
    exp_q.delete();
    for (int i = 1; i <= 3; i++) begin
      push_word(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      in_val = 1'b1; in_data = 8'hA0 + 8'(i); out_rdy = 1'b1;
      #1;
      checks++; if (o_out_val[0] !== 1'b1) begin failures++; $display("FAIL wrap_val i=%0d act=%b exp=1", i, o_out_val[0]); end
      checks++; if (o_out_data[0] !== exp_q[0]) begin failures++; $display("FAIL wrap_data i=%0d act=%h exp=%h", i, o_out_data[0], exp_q[0]); end
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(8'hA0 + 8'(i));
      checks++; if (o_count[0] !== 3'd3) begin failures++; $display("FAIL wrap_count i=%0d act=%0d exp=3", i, o_count[0]); end
    end
    in_val = 1'b0;
    while (exp_q.size() != 0) begin
      #1;
      checks++; if (o_out_data[0] !== exp_q[0]) begin failures++; $display("FAIL wrap_tail act=%h exp=%h", o_out_data[0], exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_watermarks();
    do_flush();
    afull_thr = 3'd3; aempty_thr = 3'd1;
    for (int c = 0; c < 4; c++) begin
      in_val = 1'b1; in_data = 8'(c); out_rdy = 1'b0;
      #1;
      checks++; if (o_ae[0] !== (c < 2)) begin failures++; $display("FAIL wm_aempty c=%0d act=%b exp=%b", c, o_ae[0], c < 2); end
      checks++; if (o_af[0] !== (c == 3)) begin failures++; $display("FAIL wm_afull c=%0d act=%b exp=%b", c, o_af[0], c == 3); end
      tick();
    end
    in_val = 1'b0;
    #1;
    checks++; if (o_af[0] !== 1'b1) begin failures++; $display("FAIL wm_afull_c4 act=%b exp=1", o_af[0]); end
    afull_thr = 3'd5;
    #1;
    checks++; if (o_af[0] !== 1'b0) begin failures++; $display("FAIL wm_afull_thr5 act=%b exp=0", o_af[0]); end
    aempty_thr = 3'd5;
    #1;
    checks++; if (o_ae[0] !== 1'b1) begin failures++; $display("FAIL wm_aempty_thr5 act=%b exp=1", o_ae[0]); end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 3; i++) push_word(8'h60 + 8'(i));
    #1;
    checks++; if (o_max[0] !== 3'd3) begin failures++; $display("FAIL flush_pre_max act=%0d exp=3", o_max[0]); end
    flush = 1'b1; in_val = 1'b1; in_data = 8'hEE; out_rdy = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_in_rdy[k] !== 1'b0) begin failures++; $display("FAIL flush_in_rdy[%0d] act=%b exp=0", k, o_in_rdy[k]); end
      checks++; if (o_out_val[k] !== 1'b0) begin failures++; $display("FAIL flush_out_val[%0d] act=%b exp=0", k, o_out_val[k]); end
    end
    tick();
    flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_count[k] !== 3'd0) begin failures++; $display("FAIL flush_count[%0d] act=%0d exp=0", k, o_count[k]); end
      checks++; if (o_max[k] !== 3'd0) begin failures++; $display("FAIL flush_max[%0d] act=%0d exp=0", k, o_max[k]); end
      checks++; if (o_out_val[k] !== 1'b0) begin failures++; $display("FAIL flush_post_val[%0d] act=%b exp=0", k, o_out_val[k]); end
    end
  endtask

  task automatic test_bypass();
    do_flush();
    in_val = 1'b1; in_data = 8'h5A; out_rdy = 1'b1;
    #1;
    checks++; if (o_out_val[1] !== 1'b1) begin failures++; $display("FAIL byp_val act=%b exp=1", o_out_val[1]); end
    checks++; if (o_out_data[1] !== 8'h5A) begin failures++; $display("FAIL byp_data act=%h exp=5a", o_out_data[1]); end
    checks++; if (o_out_val[0] !== 1'b0) begin failures++; $display("FAIL nobyp_val act=%b exp=0", o_out_val[0]); end
    tick();
    checks++; if (o_count[1] !== 3'd0) begin failures++; $display("FAIL byp_count act=%0d exp=0", o_count[1]); end
    out_rdy = 1'b0;
    #1;
    checks++; if (o_out_data[1] !== 8'h5A) begin failures++; $display("FAIL byp_stall_data act=%h exp=5a", o_out_data[1]); end
    tick();
    in_val = 1'b0; in_data = 8'h00;
    #1;
    checks++; if (o_count[1] !== 3'd1) begin failures++; $display("FAIL byp_store_count act=%0d exp=1", o_count[1]); end
    checks++; if (o_out_val[1] !== 1'b1) begin failures++; $display("FAIL byp_store_val act=%b exp=1", o_out_val[1]); end
    checks++; if (o_out_data[1] !== 8'h5A) begin failures++; $display("FAIL byp_store_data act=%h exp=5a", o_out_data[1]); end
    do_flush();
  endtask

  task automatic test_async_reset();
    do_flush();
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    out_rdy = 1'b1;
    tick();
    tick();
    out_rdy = 1'b0;
    #1;
    checks++; if (o_count[0] !== 3'd2) begin failures++; $display("FAIL ar_pre_count act=%0d exp=2", o_count[0]); end
    checks++; if (o_max[0] !== 3'd4) begin failures++; $display("FAIL ar_pre_max act=%0d exp=4", o_max[0]); end
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_count[k] !== 3'd0) begin failures++; $display("FAIL ar_count[%0d] act=%0d exp=0", k, o_count[k]); end
      checks++; if (o_out_val[k] !== 1'b0) begin failures++; $display("FAIL ar_out_val[%0d] act=%b exp=0", k, o_out_val[k]); end
      checks++; if (o_in_rdy[k] !== 1'b1) begin failures++; $display("FAIL ar_in_rdy[%0d] act=%b exp=1", k, o_in_rdy[k]); end
      checks++; if (o_max[k] !== 3'd0) begin failures++; $display("FAIL ar_max[%0d] act=%0d exp=0", k, o_max[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_word(8'h77);
    push_word(8'h88);
    out_rdy = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_out_data[k] !== 8'h77) begin failures++; $display("FAIL ar_first_pop[%0d] act=%h exp=77", k, o_out_data[k]); end
    end
    tick();
    #1;
    checks++; if (o_out_data[0] !== 8'h88) begin failures++; $display("FAIL ar_second_pop act=%h exp=88", o_out_data[0]); end
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_random();
    logic       e_rdy, e_val, e_byp, e_push, e_pop;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    do_flush();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mmax[k] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      flush      = ($urandom_range(0, 24) == 0);
      in_val     = ($urandom_range(0, 9) < ((n % 100) < 50 ? 8 : 3));
      out_rdy    = ($urandom_range(0, 9) < ((n % 100) < 50 ? 3 : 8));
      in_data    = 8'($urandom);
      afull_thr  = 3'($urandom_range(0, 7));
      aempty_thr = 3'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < 2; k++) begin
        e_cnt  = 3'(mq[k].size());
        e_rdy  = (mq[k].size() != 4) && !flush;
        e_byp  = (k == 1) && (mq[k].size() == 0) && in_val && !flush;
        e_val  = ((mq[k].size() != 0) || e_byp) && !flush;
        e_data = e_byp ? in_data : ((mq[k].size() != 0) ? mq[k][0] : 8'h00);
        checks++; if (o_in_rdy[k] !== e_rdy) begin failures++; $display("FAIL rnd_in_rdy[%0d] n=%0d act=%b exp=%b", k, n, o_in_rdy[k], e_rdy); end
        checks++; if (o_out_val[k] !== e_val) begin failures++; $display("FAIL rnd_out_val[%0d] n=%0d act=%b exp=%b", k, n, o_out_val[k], e_val); end
        if (e_val) begin
          checks++; if (o_out_data[k] !== e_data) begin failures++; $display("FAIL rnd_out_data[%0d] n=%0d act=%h exp=%h", k, n, o_out_data[k], e_data); end
        end
        checks++; if (o_count[k] !== e_cnt) begin failures++; $display("FAIL rnd_count[%0d] n=%0d act=%0d exp=%0d", k, n, o_count[k], e_cnt); end
        checks++; if (o_max[k] !== 3'(mmax[k])) begin failures++; $display("FAIL rnd_max[%0d] n=%0d act=%0d exp=%0d", k, n, o_max[k], mmax[k]); end
        checks++; if (o_af[k] !== (e_cnt >= afull_thr)) begin failures++; $display("FAIL rnd_afull[%0d] n=%0d act=%b exp=%b", k, n, o_af[k], e_cnt >= afull_thr); end
        checks++; if (o_ae[k] !== (e_cnt <= aempty_thr)) begin failures++; $display("FAIL rnd_aempty[%0d] n=%0d act=%b exp=%b", k, n, o_ae[k], e_cnt <= aempty_thr); end
        if (flush) begin
          mq[k].delete();
          mmax[k] = 0;
        end else begin
          e_push = in_val && e_rdy;
          e_pop  = e_val && out_rdy;
          if (!(e_byp && out_rdy)) begin
            if (e_pop) void'(mq[k].pop_front());
            if (e_push) mq[k].push_back(in_data);
          end
          if (mq[k].size() > mmax[k]) mmax[k] = mq[k].size();
        end
      end
      tick();
    end
    flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_watermarks();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised successor to the basic valid/ready FIFO.
- Adds occupancy reporting, programmable almost-full/almost-empty watermarks, a high-water-mark register, synchronous flush, and an optional zero-latency bypass (fall-through) mode.
- Sits between a producer and consumer on any valid/ready stream.
- Used where upstream flow control needs early warning before full/empty.

Parameters:
- DEPTH_IDX, 2, log2 of number of slots; DEPTH = 2**DEPTH_IDX, DEPTH_IDX >= 1.
- WIDTH, 8, data width in bits.
- BYPASS, 0, 1 = when empty, push data is forwarded to the output in the same cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_val  in  1  push request.
- in_rdy  out  1  FIFO can accept push.
- in_data  in  WIDTH  push data.
- out_val  out  1  pop data valid.
- out_rdy  in  1  consumer accepts pop.
- out_data  out  WIDTH  pop data, valid in the same cycle as out_val.
- afull_thr  in  DEPTH_IDX+1  almost-full threshold.
- aempty_thr  in  DEPTH_IDX+1  almost-empty threshold.
- count  out  DEPTH_IDX+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= afull_thr.
- almost_empty  out  1  count <= aempty_thr.
- max_count  out  DEPTH_IDX+1  high-water mark since reset/flush.

Behaviour:
- Reset (async, rst_n=0):
  - wr/rd pointers = 0, count = 0, max_count = 0.
  - Outputs: in_rdy=1, out_val=0, almost_empty=1 if aempty_thr>=0 (always), almost_full=(afull_thr==0).
  - Storage is not reset; out_data is don't-care while out_val=0.
- Push: push = in_val && in_rdy. Write in_data at wr_ptr; wr_ptr advances by 1, wraps DEPTH-1 -> 0 via natural overflow.
- Pop: pop = out_val && out_rdy. rd_ptr advances by 1, wraps DEPTH-1 -> 0.
- out_data = storage[rd_ptr], combinational (no read latency).
- in_rdy = (count != DEPTH) && !flush. No combinational path from out_rdy to in_rdy: a full FIFO refuses a push even while popping.
- out_val = (count != 0 || bypass_hit) && !flush.
- Count update on the next cycle:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - Never exceeds DEPTH; never underflows.
- Simultaneous push and pop at count = 1..DEPTH-1: both pointers advance, count unchanged, data order preserved.
- Bypass mode (BYPASS=1):
  - bypass_hit = count==0 && in_val && !flush.
  - When bypass_hit: out_val=1 and out_data=in_data in the same cycle.
  - If out_rdy=1 as well: the word is consumed directly, pointers and count are unchanged, nothing is stored.
  - If out_rdy=0: the word is stored normally (count becomes 1).
- BYPASS=0: an empty FIFO has out_val=0 regardless of in_val; minimum latency push to pop is 1 cycle.
- Flush (sync, highest priority after reset):
  - In the flush cycle, in_rdy=0 and out_val=0, so no push or pop occurs.
  - Next cycle: pointers = 0, count = 0, max_count = 0.
  - Flush held for multiple cycles keeps the FIFO empty.
- Watermarks:
  - almost_full and almost_empty are combinational from the count register and threshold inputs.
  - Thresholds may change at any time; outputs follow immediately.
  - Thresholds > DEPTH are legal: almost_full is never asserted, almost_empty is always asserted.
- max_count: next cycle = max(max_count, next count). Monotonic except on flush/reset.
- Protocol:
  - Once in_val is asserted it is held with stable in_data until in_rdy (producer obligation).
  - out_val, once asserted with out_rdy=0, stays asserted with stable out_data until popped or flushed.
- Reset mid-operation: all state is cleared immediately (async); previously stored data is unreachable.

Test Plan:
- DEPTH_IDX=2, WIDTH=8, BYPASS=0: push 0x11,0x22,0x33,0x44 with out_rdy=0 -> count 1,2,3,4; in_rdy=0 after 4th; 5th in_val held stalls. Then pop 4 -> out_data 0x11,0x22,0x33,0x44 in order, count back to 0, out_val=0.
- Wrap with concurrency: fill 3 words, then 8 cycles of simultaneous push (0xA0..0xA7) and pop -> count stays 3 throughout; output order is the 3 initial words followed by 0xA0.., with no gaps; pointers wrap twice.
- Watermarks: afull_thr=3, aempty_thr=1, push one word per cycle -> almost_empty=1 at count 0,1 and 0 at count 2; almost_full asserts at count 3. Change afull_thr to 5 at count 4 -> almost_full deasserts in the same cycle.
- Flush: count=3, max_count=3, assert flush one cycle with in_val=1, out_rdy=1 -> in_rdy=0 and out_val=0 that cycle; next cycle count=0, max_count=0, out_val=0, and the pushed word is not stored.
- Bypass (BYPASS=1): empty, in_val=1, in_data=0x5A, out_rdy=1 -> out_val=1 and out_data=0x5A the same cycle; count stays 0. Repeat with out_rdy=0 -> count=1, and next cycle out_data=0x5A.
- Async reset with count=2 and max_count=4 -> immediately count=0, out_val=0, in_rdy=1, max_count=0; first push after release is popped first.
